// File: rtl/qos_param_pkg.sv
// Shared definitions for the parametrised QoS block:
// FSM encodings, arbitration modes and a FIFO count-width helper.
package qos_param_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic RR  = 1'b0;
    localparam logic WRR = 1'b1;

    // Counts must hold DEPTH itself, hence one bit above the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/qos_fifo.sv
// Synchronous first-word-fall-through FIFO with count and flush.
// Push while full is accepted only when a pop happens on the same edge.
module qos_fifo
    import qos_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [DATA_W-1:0]         i_data,
    output logic [DATA_W-1:0]         o_data,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = o_empty ? '0 : r_mem[r_rptr];
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/qos_param.sv
// N virtual-channel input FIFOs merged into one egress FIFO by a
// RR / weighted-RR arbiter, with hysteresis pause and sticky overflow.
module qos_param
    import qos_param_pkg::*;
#(
    parameter int NUM_VC    = 4,
    parameter int DATA_W    = 8,
    parameter int VC_DEPTH  = 8,
    parameter int OUT_DEPTH = 16,
    parameter int WEIGHT_W  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic                         iniciar,
    input  logic                         mode,
    input  logic [NUM_VC*WEIGHT_W-1:0]   weights,
    input  logic [$clog2(VC_DEPTH):0]    umbral_max,
    input  logic [$clog2(VC_DEPTH):0]    umbral_min,
    input  logic                         in_valid,
    input  logic [$clog2(NUM_VC)-1:0]    in_vc,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [NUM_VC-1:0]            pausa,
    output logic [NUM_VC-1:0]            error_full,
    output logic                         idle,
    output logic [1:0]                   estado
);
    localparam int VCW = cnt_w(VC_DEPTH);
    localparam int OCW = cnt_w(OUT_DEPTH);
    localparam int VIW = $clog2(NUM_VC);

    state_t                       r_state;
    logic                         r_idle;
    logic                         r_mode;
    logic [NUM_VC*WEIGHT_W-1:0]   r_weights;
    logic [VCW-1:0]               r_umax;
    logic [VCW-1:0]               r_umin;
    logic [VIW-1:0]               r_ptr;
    logic [WEIGHT_W-1:0]          r_cred;
    logic [NUM_VC-1:0]            r_pausa;
    logic [NUM_VC-1:0]            r_err;

    logic [NUM_VC-1:0]  w_vc_push;
    logic [NUM_VC-1:0]  w_vc_pop;
    logic [NUM_VC-1:0]  w_vc_full;
    logic [NUM_VC-1:0]  w_vc_empty;
    logic [DATA_W-1:0]  w_vc_data [NUM_VC];
    logic [VCW-1:0]     w_vc_cnt  [NUM_VC];
    logic [OCW-1:0]     w_out_cnt;
    logic               w_out_full;
    logic               w_out_empty;

    logic                w_wr_en;
    logic                w_ovf;
    logic                w_flush;
    logic                w_out_pop;
    logic                w_arb_en;
    logic                w_found;
    logic                w_gnt;
    logic [VIW-1:0]      w_gnt_vc;
    logic [VIW:0]        w_idx;
    logic [WEIGHT_W-1:0] w_wt;
    logic [WEIGHT_W-1:0] w_wt_eff;
    logic [WEIGHT_W-1:0] w_cred_new;
    logic [VIW-1:0]      w_nxt;
    logic                w_move;
    logic                w_drained;

    assign w_wr_en   = enb && in_valid && (r_state == IDLE || r_state == ACTIVE);
    assign w_ovf     = w_wr_en && w_vc_full[in_vc];
    assign w_flush   = enb && iniciar && (r_state == ERROR);
    assign w_out_pop = enb && out_valid && out_ready;
    assign w_arb_en  = enb && !w_flush && (r_state == ACTIVE || r_state == ERROR)
                       && (!w_out_full || w_out_pop);
    assign w_gnt     = w_arb_en && w_found;
    assign w_drained = (&w_vc_empty) && w_out_empty;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        assign w_vc_push[g] = w_wr_en && !w_vc_full[g] && (in_vc == VIW'(g));
        assign w_vc_pop[g]  = w_gnt && (w_gnt_vc == VIW'(g));
        qos_fifo #(.DATA_W(DATA_W), .DEPTH(VC_DEPTH)) u_vc (
            .clk(clk), .rst(rst), .i_flush(w_flush),
            .i_push(w_vc_push[g]), .i_pop(w_vc_pop[g]), .i_data(in_data),
            .o_data(w_vc_data[g]), .o_count(w_vc_cnt[g]),
            .o_full(w_vc_full[g]), .o_empty(w_vc_empty[g])
        );
    end

    qos_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_out (
        .clk(clk), .rst(rst), .i_flush(w_flush),
        .i_push(w_gnt), .i_pop(w_out_pop), .i_data(w_vc_data[w_gnt_vc]),
        .o_data(out_data), .o_count(w_out_cnt),
        .o_full(w_out_full), .o_empty(w_out_empty)
    );

    // First non-empty VC at or after the pointer, wrapping at NUM_VC.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_vc = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            w_idx = {1'b0, r_ptr} + (VIW+1)'(k);
            if (w_idx >= (VIW+1)'(NUM_VC)) w_idx = w_idx - (VIW+1)'(NUM_VC);
            if (!w_found && !w_vc_empty[w_idx[VIW-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_vc = w_idx[VIW-1:0];
            end
        end
    end

    assign w_wt       = r_weights[w_gnt_vc*WEIGHT_W +: WEIGHT_W];
    assign w_wt_eff   = (w_wt == '0) ? WEIGHT_W'(1) : w_wt;
    assign w_cred_new = ((w_gnt_vc == r_ptr) ? r_cred : '0) + WEIGHT_W'(1);
    assign w_nxt      = (w_gnt_vc == VIW'(NUM_VC-1)) ? '0 : w_gnt_vc + 1'b1;
    assign w_move     = (r_mode == RR) || (w_cred_new >= w_wt_eff)
                        || ((w_vc_cnt[w_gnt_vc] == VCW'(1)) && !w_vc_push[w_gnt_vc]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_cred <= '0;
        end else if (w_flush) begin
            r_ptr  <= '0;
            r_cred <= '0;
        end else if (w_gnt) begin
            r_ptr  <= w_move ? w_nxt : w_gnt_vc;
            r_cred <= w_move ? '0 : w_cred_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pausa <= '0;
            r_err   <= '0;
        end else if (enb) begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (w_vc_cnt[i] >= r_umax)      r_pausa[i] <= 1'b1;
                else if (w_vc_cnt[i] <= r_umin) r_pausa[i] <= 1'b0;
            end
            if (w_flush)    r_err        <= '0;
            else if (w_ovf) r_err[in_vc] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= INIT;
            r_idle    <= 1'b0;
            r_mode    <= RR;
            r_weights <= {NUM_VC{WEIGHT_W'(1)}};
            r_umax    <= VCW'(VC_DEPTH);
            r_umin    <= '0;
        end else if (enb) begin
            unique case (r_state)
                INIT: if (iniciar) begin
                    r_mode    <= mode;
                    r_weights <= weights;
                    r_umax    <= umbral_max;
                    r_umin    <= umbral_min;
                    r_state   <= IDLE;
                    r_idle    <= 1'b1;
                end
                IDLE: if (w_ovf) begin
                    r_state <= ERROR;
                    r_idle  <= 1'b0;
                end else if (w_wr_en) begin
                    r_state <= ACTIVE;
                    r_idle  <= 1'b0;
                end
                ACTIVE: if (w_ovf) begin
                    r_state <= ERROR;
                end else if (w_drained && !in_valid) begin
                    r_state <= IDLE;
                    r_idle  <= 1'b1;
                end
                ERROR: if (iniciar) r_state <= INIT;
                default: r_state <= INIT;
            endcase
        end
    end

    assign out_valid  = (w_out_cnt != '0);
    assign pausa      = r_pausa;
    assign error_full = r_err;
    assign idle       = r_idle;
    assign estado     = r_state;

endmodule

// File: tb/tb_qos_param.sv
// Scoreboard bench for qos_param: egress words are checked against
// a queue of expected words filled as stimulus is driven.
module tb_qos_param;
    import qos_param_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        iniciar;
    logic        mode;
    logic [23:0] weights;
    logic [3:0]  umbral_max;
    logic [3:0]  umbral_min;
    logic        in_valid;
    logic [1:0]  in_vc;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  pausa;
    logic [3:0]  error_full;
    logic        idle;
    logic [1:0]  estado;

    qos_param #(
        .NUM_VC(4), .DATA_W(8), .VC_DEPTH(8), .OUT_DEPTH(16), .WEIGHT_W(6)
    ) dut (
        .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar), .mode(mode),
        .weights(weights), .umbral_max(umbral_max), .umbral_min(umbral_min),
        .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .pausa(pausa), .error_full(error_full), .idle(idle), .estado(estado)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         m_idx;
    bit         ordered = 1'b1;
    logic [7:0] exp_q[$];

    localparam logic [23:0] W_ONES = {6'd1, 6'd1, 6'd1, 6'd1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-VC order is all that is guaranteed under random backpressure,
    // so unordered mode matches the oldest entry carrying the same VC tag.
    always @(negedge clk) begin
        if (!rst && enb && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", exp_q.size(), 1);
            end else if (ordered) begin
                chk("out_data", out_data, exp_q.pop_front());
            end else begin
                m_idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (m_idx < 0 && exp_q[i][7:6] == out_data[7:6]) m_idx = i;
                chk("out_vc_seen", m_idx >= 0, 1);
                if (m_idx >= 0) begin
                    chk("out_vc_data", out_data, exp_q[m_idx]);
                    exp_q.delete(m_idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enb = 1'b1; iniciar = 1'b0; in_valid = 1'b0;
        in_vc = '0; in_data = '0; out_ready = 1'b0;
        mode = 1'b0; weights = W_ONES; umbral_max = 4'd8; umbral_min = 4'd0;
        exp_q.delete();
        ordered = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic init_cfg(input logic m, input logic [23:0] w,
                            input logic [3:0] mx, input logic [3:0] mn);
        mode = m; weights = w; umbral_max = mx; umbral_min = mn;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic push(input logic [1:0] vc, input logic [7:0] d, input bit track);
        in_valid = 1'b1; in_vc = vc; in_data = d;
        if (track) exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    // One word at a time through VC3 so it empties after each grant,
    // leaving the pointer on VC0 and the egress FIFO full.
    task automatic fill_out();
        for (int k = 0; k < 16; k++) begin
            push(2'd3, 8'h10 + 8'(k), 1'b1);
            tick();
        end
    endtask

    task automatic drain(input string tag, input int budget, input logic [1:0] st);
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
        repeat (4) tick();
        chk({tag, "_state"}, estado, st);
        chk({tag, "_empty"}, out_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and asynchronous reset mid-traffic.
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pausa", pausa, 0);
        chk("rst_err", error_full, 0);
        chk("rst_idle", idle, 0);
        chk("rst_state", estado, INIT);
        init_cfg(RR, W_ONES, 4'd8, 4'd0);
        chk("cfg_state", estado, IDLE);
        chk("cfg_idle", idle, 1);
        for (int k = 0; k < 3; k++) push(2'd1, 8'h20 + 8'(k), 1'b0);
        repeat (2) tick();
        chk("t1_loaded", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_valid", out_valid, 0);
        chk("t1_async_state", estado, INIT);
        chk("t1_async_data", out_data, 0);
        tick();
        rst = 1'b0;
        tick();
        init_cfg(RR, W_ONES, 4'd8, 4'd0);
        repeat (2) tick();
        chk("t1_counts_zero", out_valid, 0);

        // Plain round robin, with an enable pause mid-drain.
        do_reset();
        init_cfg(RR, W_ONES, 4'd8, 4'd0);
        fill_out();
        for (int v = 0; v < 4; v++)
            for (int j = 0; j < 2; j++)
                push(2'(v), 8'hA0 + 8'(16 * v + j), 1'b0);
        for (int j = 0; j < 2; j++)
            for (int v = 0; v < 4; v++)
                exp_q.push_back(8'hA0 + 8'(16 * v + j));
        out_ready = 1'b1;
        repeat (3) tick();
        enb = 1'b0;
        repeat (3) tick();
        enb = 1'b1;
        drain("rr", 200, IDLE);

        // Weighted RR, VC3 weight 3.
        do_reset();
        init_cfg(WRR, {6'd3, 6'd1, 6'd1, 6'd1}, 4'd8, 4'd0);
        fill_out();
        for (int k = 0; k < 4; k++) push(2'd0, 8'h00 + 8'(k), 1'b0);
        for (int k = 0; k < 4; k++) push(2'd3, 8'h30 + 8'(k), 1'b0);
        exp_q.push_back(8'h00); exp_q.push_back(8'h30);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        exp_q.push_back(8'h01); exp_q.push_back(8'h33);
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        drain("wrr", 200, IDLE);

        // Hysteresis on VC2: set at count 6, release at count 2.
        do_reset();
        init_cfg(RR, W_ONES, 4'd6, 4'd2);
        fill_out();
        for (int k = 0; k < 6; k++) push(2'd2, 8'h50 + 8'(k), 1'b1);
        chk("hyst_pre", pausa[2], 0);
        tick();
        chk("hyst_set", pausa[2], 1);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("hyst_hold", pausa[2], 1);
        tick();
        chk("hyst_clr", pausa[2], 0);
        drain("hyst", 200, IDLE);

        // Overflow on VC1, then recovery through iniciar.
        do_reset();
        init_cfg(RR, W_ONES, 4'd8, 4'd0);
        fill_out();
        for (int k = 0; k < 8; k++) push(2'd1, 8'h60 + 8'(k), 1'b1);
        chk("ovf_none", error_full, 0);
        chk("ovf_active", estado, ACTIVE);
        push(2'd1, 8'h68, 1'b0);
        chk("ovf_flag", error_full, 4'b0010);
        chk("ovf_state", estado, ERROR);
        push(2'd0, 8'h70, 1'b0);
        chk("ovf_ignored", error_full, 4'b0010);
        drain("ovf", 200, ERROR);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("ovf_clear", error_full, 0);
        chk("ovf_init", estado, INIT);

        // Backpressure with all VCs loaded; tag = VC in top two bits.
        do_reset();
        init_cfg(RR, W_ONES, 4'd8, 4'd0);
        ordered = 1'b0;
        for (int c = 0; c < 32; c++) begin
            out_ready = c[0];
            push(2'(c % 4), {2'(c % 4), 6'(c / 4)}, 1'b1);
        end
        for (int c = 0; c < 8; c++) begin
            out_ready = c[0];
            tick();
        end
        drain("bp", 400, IDLE);
        chk("bp_err", error_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qos_param.md
Name: qos_param

Overview:
- Parametrised next-generation QoS block: N virtual-channel (VC) input FIFOs feed an output FIFO through a configurable round-robin / weighted round-robin arbiter.
- Per-VC hysteresis flow control (pausa) and sticky overflow errors.
- A control FSM gated by iniciar.
- Sits between the link demux and the egress port; replaces the fixed 4-VC, 4-bit QoS path.

Parameters:
NUM_VC, 4, number of virtual channels (>=2)
DATA_W, 8, data word width
VC_DEPTH, 8, words per VC FIFO (power of 2)
OUT_DEPTH, 16, words in output FIFO (power of 2)
WEIGHT_W, 6, width of each per-VC weight

Ports:
clk  in  1  clock
rst  in  1  reset
enb  in  1  global enable; when 0, all state holds and no push/pop/grant occurs
iniciar  in  1  latch configuration / leave ERROR
mode  in  1  0 = plain RR, 1 = weighted RR (latched on iniciar)
weights  in  NUM_VC*WEIGHT_W  per-VC weight, VC i at [i*WEIGHT_W +: WEIGHT_W] (latched)
umbral_max  in  $clog2(VC_DEPTH)+1  pause-assert threshold (latched)
umbral_min  in  $clog2(VC_DEPTH)+1  pause-release threshold (latched)
in_valid  in  1  input word present
in_vc  in  $clog2(NUM_VC)  target VC
in_data  in  DATA_W  input word
out_ready  in  1  downstream accepts
out_valid  out  1  output FIFO non-empty
out_data  out  DATA_W  output FIFO head (first-word fall-through)
pausa  out  NUM_VC  per-VC pause request
error_full  out  NUM_VC  sticky per-VC overflow flag
idle  out  1  FSM in IDLE
estado  out  2  FSM state, for debug

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - Outputs: out_valid=0, out_data=0, pausa=0, error_full=0, idle=0, estado=INIT.
  - Internal state: all FIFO pointers and counts 0, grant pointer 0, weight credit 0.
  - Latched configuration: mode=0, weights=all 1, umbral_max=VC_DEPTH, umbral_min=0.
- FSM states (shared package): INIT=0, IDLE=1, ACTIVE=2, ERROR=3.
  - INIT: inputs ignored. iniciar=1 latches mode, weights and thresholds, then -> IDLE.
  - IDLE: all FIFOs empty. Accepted in_valid -> ACTIVE.
  - ACTIVE: when all VC FIFOs and the output FIFO are empty and in_valid=0 -> IDLE.
  - Any write to a full VC, in IDLE or ACTIVE -> ERROR.
  - ERROR: writes ignored; arbitration and output drain continue. iniciar=1 clears error_full, flushes all FIFOs, -> INIT.
- Write path:
  - A push occurs when in_valid and the state is IDLE or ACTIVE.
  - Push to a full VC: word dropped, error_full[in_vc] set. This holds even if the same VC is popped in the same cycle, because full is judged on the pre-cycle count.
- Flow control, per VC, evaluated on the registered count:
  - pausa[i] is set the cycle after count >= umbral_max.
  - pausa[i] is cleared the cycle after count <= umbral_min.
  - If both conditions are true, set has priority.
  - pausa is advisory: writes are still accepted.
- Arbiter (in ACTIVE or ERROR):
  - Grants one non-empty VC per cycle when the output FIFO is not full, or is being popped in that cycle.
  - The granted VC pops; its word is written to the output FIFO on the same edge, so it is visible on out_data one cycle after the grant.
  - Search order: starting from the pointer, the first non-empty VC in increasing index order, wrapping at NUM_VC.
  - mode 0: the pointer moves to granted+1 after every grant.
  - mode 1: the pointer stays on the granted VC until it has received weight[i] consecutive grants (weight 0 treated as 1) or it goes empty, then moves to granted+1.
  - The credit counter reloads on every pointer move.
- Output:
  - out_valid = output count != 0.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop is legal at any fill level, including full.
- Widths:
  - Counts are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
  - Threshold compares are unsigned.

Decomposition:
- Package qos_param_pkg: state encodings (INIT, IDLE, ACTIVE, ERROR), mode constants RR=0 and WRR=1, and a clog2-based width helper.
- One sub-module, qos_fifo: synchronous FIFO parametrised by DATA_W and DEPTH, with count, full and empty outputs plus a flush input. Instantiated NUM_VC+1 times via generate.
- The arbiter and FSM stay inline.

Test Plan:
1. Reset mid-traffic: assert rst while VC1 holds 3 words -> all outputs reset immediately (asynchronously), out_valid=0, estado=INIT, counts 0.
2. RR fairness: mode=0; preload VC0..VC3 with 2 words each (0xA0,0xA1,0xB0,...); out_ready=1 -> out_data order A0,B0,C0,D0,A1,B1,C1,D1.
3. WRR: mode=1, weights={1,1,1,3} (VC3 last); VC0 and VC3 each preloaded with 4 words -> order VC0,VC3,VC3,VC3,VC0,VC3,VC0,VC0.
4. Hysteresis: umbral_max=6, umbral_min=2, out_ready=0, output FIFO full; push 6 words to VC2 -> pausa[2]=1 the cycle after count reaches 6. Release out_ready -> pausa[2] clears the cycle after count reaches 2.
5. Overflow: fill VC1 to 8 words with arbitration blocked, then push a 9th -> error_full[1]=1, estado=ERROR, word dropped. The remaining 8 words drain. iniciar -> error_full=0, estado=INIT.
6. Backpressure: toggle out_ready 1/0 every cycle with all VCs loaded -> no word lost or duplicated; output FIFO count never exceeds 16.
